// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: select codes, driver FSM states
// and a reference model of the 8-bit combinational ALU.
package alu_pkg;

    localparam int unsigned ALU_W = 8;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_MUL = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;
    localparam logic [1:0] ALU_SHL = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } drv_state_e;

    // Returns {carry, zf, result}; carry is always the add carry, as the ALU reports it.
    function automatic logic [ALU_W+1:0] alu_model(input logic [ALU_W-1:0] a,
                                                   input logic [ALU_W-1:0] b,
                                                   input logic [1:0]       sel);
        logic [ALU_W:0]   sum;
        logic [ALU_W-1:0] res;
        sum = {1'b0, a} + {1'b0, b};
        case (sel)
            ALU_ADD: res = sum[ALU_W-1:0];
            ALU_MUL: res = a * b;
            ALU_XOR: res = a ^ b;
            default: res = {a[ALU_W-2:0], 1'b0};
        endcase
        return {sum[ALU_W], (res == '0), res};
    endfunction

endpackage

// File: rtl/alu_op_driver.sv
// Sequential front end for the combinational ALU: accepts a request, drives
// registered operands, waits SETTLE_CYCLES, captures the result and returns it.
// Optional result checker enabled by `define ALU_DRV_CHECK_EN (adds rsp_err).
module alu_op_driver
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH         = ALU_W,
    parameter int unsigned TAG_W         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_sel,
    input  logic             req_chain,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zf,
    output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_DRV_CHECK_EN
    ,
    output logic             rsp_err
`endif
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    drv_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] alu_a_d, alu_b_d;
    logic [1:0]       alu_sel_d;
    logic             req_ready_d, rsp_valid_d, rsp_carry_d, rsp_zf_d;
    logic [WIDTH-1:0] rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_d;

`ifdef ALU_DRV_CHECK_EN
    logic             rsp_err_d;
    logic [ALU_W+1:0] exp_c;
    logic             mismatch_c;

    // Reference result for the operands currently held on the ALU inputs.
    always_comb begin
        exp_c      = alu_model(ALU_W'(alu_a), ALU_W'(alu_b), alu_sel);
        mismatch_c = (alu_out != WIDTH'(exp_c[ALU_W-1:0])) ||
                     (alu_zf != exp_c[ALU_W]) ||
                     ((alu_sel == ALU_ADD) && (alu_carry != exp_c[ALU_W+1]));
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        tag_d       = tag_q;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_sel_d   = alu_sel;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_carry_d = rsp_carry;
        rsp_zf_d    = rsp_zf;
        rsp_tag_d   = rsp_tag;
`ifdef ALU_DRV_CHECK_EN
        rsp_err_d   = rsp_err;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    alu_a_d   = req_chain ? acc_q : req_a;
                    alu_b_d   = req_b;
                    alu_sel_d = req_sel;
                    tag_d     = req_tag;
                    cnt_d     = CNT_LOAD;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                rsp_data_d  = alu_out;
                rsp_carry_d = alu_carry;
                rsp_zf_d    = alu_zf;
                rsp_tag_d   = tag_q;
                acc_d       = alu_out;
                rsp_valid_d = 1'b1;
`ifdef ALU_DRV_CHECK_EN
                rsp_err_d   = mismatch_c;
`endif
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
`ifdef ALU_DRV_CHECK_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Ready is registered, so it is derived from where the FSM is going.
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            tag_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zf    <= 1'b0;
            rsp_tag   <= '0;
`ifdef ALU_DRV_CHECK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            tag_q     <= tag_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_sel   <= alu_sel_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_carry <= rsp_carry_d;
            rsp_zf    <= rsp_zf_d;
            rsp_tag   <= rsp_tag_d;
`ifdef ALU_DRV_CHECK_EN
            rsp_err   <= rsp_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver with a behavioural ALU attached.
// Also exercises the result checker when built with ALU_DRV_CHECK_EN.
module tb_alu_op_driver;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned SETTLE = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_sel;
    logic             req_chain;
    logic [TAG_W-1:0] req_tag;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             alu_zf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_zf;
    logic [TAG_W-1:0] rsp_tag;
`ifdef ALU_DRV_CHECK_EN
    logic             rsp_err;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int acc_m    = 0;
    logic corrupt = 1'b0;

    alu_op_driver #(
        .WIDTH         (WIDTH),
        .TAG_W         (TAG_W),
        .SETTLE_CYCLES (SETTLE)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .req_chain (req_chain),
        .req_tag   (req_tag),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .alu_zf    (alu_zf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zf    (rsp_zf),
        .rsp_tag   (rsp_tag)
`ifdef ALU_DRV_CHECK_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; 'corrupt' flips the LSB of the result to fake a faulty ALU.
    logic [8:0] emu_sum;
    logic [7:0] emu_res;
    always_comb begin
        emu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        case (alu_sel)
            2'd0:    emu_res = emu_sum[7:0];
            2'd1:    emu_res = alu_a * alu_b;
            2'd2:    emu_res = alu_a ^ alu_b;
            default: emu_res = alu_a << 1;
        endcase
        alu_out   = emu_res ^ {7'd0, corrupt};
        alu_carry = emu_sum[8];
        alu_zf    = (emu_res == 8'd0);
    end

    function automatic void ref_op(input int a, input int b, input int sel,
                                   output int r, output int c, output int z);
        c = ((a + b) > 255) ? 1 : 0;
        case (sel)
            0:       r = (a + b) % 256;
            1:       r = (a * b) % 256;
            2:       r = a ^ b;
            default: r = (a * 2) % 256;
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for ready, presents one request for the accepting edge, returns the A the DUT should use.
    task automatic issue(input int a, input int b, input int sel, input bit chain,
                         input int tag, output int exp_a);
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("req_ready_before_issue", req_ready, 1);
        req_valid = 1'b1;
        req_a     = 8'(a);
        req_b     = 8'(b);
        req_sel   = 2'(sel);
        req_chain = chain;
        req_tag   = 4'(tag);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_a     = chain ? acc_m : a;
    endtask

    // Waits for the response, checks it, holds it for 'hold' cycles, then handshakes.
    task automatic collect(input int exp_a, input int b, input int sel, input int tag,
                           input int hold);
        int r, c, z, k, r_obs;
        ref_op(exp_a, b, sel, r, c, z);
        r_obs = corrupt ? (r ^ 1) : r;
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (rsp_valid === 1'b1) break;
        end
        chk("latency", k, SETTLE + 1);
        chk("rsp_data", rsp_data, r_obs);
        chk("rsp_carry", rsp_carry, c);
        chk("rsp_zf", rsp_zf, z);
        chk("rsp_tag", rsp_tag, tag);
        chk("alu_a", alu_a, exp_a);
        chk("alu_b", alu_b, b);
        chk("alu_sel", alu_sel, sel);
`ifdef ALU_DRV_CHECK_EN
        chk("rsp_err", rsp_err, corrupt ? 1 : 0);
`endif
        acc_m = r_obs;
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, r_obs);
            chk("hold_tag", rsp_tag, tag);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("valid_cleared", rsp_valid, 0);
        chk("ready_after_rsp", req_ready, 1);
`ifdef ALU_DRV_CHECK_EN
        chk("err_cleared", rsp_err, 0);
`endif
    endtask

    initial begin
        int ea, ea3, seen;
        int ra, rb, rs, rt, rh;
        bit rc;

        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        req_chain = 1'b0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        #3 rst_n = 1'b0;
        #10;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed operations
        issue(8'h0F, 8'h01, 0, 1'b0, 1, ea); collect(ea, 8'h01, 0, 1, 0);
        issue(8'hFF, 8'h01, 0, 1'b0, 2, ea); collect(ea, 8'h01, 0, 2, 1);
        issue(8'h10, 8'h10, 1, 1'b0, 5, ea); collect(ea, 8'h10, 1, 5, 0);
        issue(8'h03, 8'h05, 1, 1'b0, 6, ea); collect(ea, 8'h05, 1, 6, 0);
        issue(8'h03, 8'h04, 0, 1'b0, 7, ea); collect(ea, 8'h04, 0, 7, 0);
        issue(8'hAA, 8'h00, 3, 1'b1, 8, ea); collect(ea, 8'h00, 3, 8, 0);
        issue(8'h55, 8'hFF, 2, 1'b1, 9, ea); collect(ea, 8'hFF, 2, 9, 0);
        chk("chain_result", acc_m, 8'hF1);

        // Reset in the middle of SETTLE drops the op and clears the accumulator
        issue(8'h05, 8'h06, 0, 1'b0, 10, ea);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_sel", alu_sel, 0);
        chk("mid_rst_data", rsp_data, 0);
        acc_m = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen++;
        end
        chk("no_rsp_after_rst", seen, 0);
        issue(8'h77, 8'h09, 0, 1'b1, 11, ea); collect(ea, 8'h09, 0, 11, 0);

        // Backpressure: second request waits until IDLE after the handshake
        issue(8'h12, 8'h34, 0, 1'b0, 3, ea3);
        req_valid = 1'b1;
        req_a     = 8'h22;
        req_b     = 8'h11;
        req_sel   = 2'd2;
        req_chain = 1'b0;
        req_tag   = 4'h4;
        collect(ea3, 8'h34, 0, 3, 5);
        chk("bp_not_early", alu_a, 8'h12);
        @(posedge clk); #1;
        req_valid = 1'b0;
        collect(8'h22, 8'h11, 2, 4, 0);

        // Randomized operations against the reference model
        for (int n = 0; n < 20; n++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            rs = int'($urandom_range(0, 3));
            rt = int'($urandom_range(0, 15));
            rh = int'($urandom_range(0, 2));
            rc = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, rc, rt, ea);
            collect(ea, rb, rs, rt, rh);
        end

`ifdef ALU_DRV_CHECK_EN
        corrupt = 1'b1;
        issue(8'h21, 8'h13, 1, 1'b0, 12, ea); collect(ea, 8'h13, 1, 12, 0);
        corrupt = 1'b0;
        issue(8'h21, 8'h13, 0, 1'b0, 13, ea); collect(ea, 8'h13, 0, 13, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
- Sequential front end that issues operations to the team's combinational 8-bit `alu` and returns registered results.
- Accepts operation requests on a valid/ready interface and drives the ALU operand and select ports from registers.
- Waits a programmable settle time, samples the ALU result and flags, then presents a response on a second valid/ready interface.
- Sits between a command source (sequencer or testbench master) and the `alu` instance. It is the initiator for the ALU's responder.

Parameters:
- WIDTH, 8: operand/result width; must match the ALU.
- TAG_W, 4: width of the request tag echoed on the response.
- SETTLE_CYCLES, 1: cycles from operand launch to result sample; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_sel  in  2  operation: 00 add, 01 mul, 10 xor, 11 shift-left-1.
- req_chain  in  1  1 = use the last captured result as A, ignoring req_a.
- req_tag  in  TAG_W  opaque tag.
- alu_a  out  WIDTH  registered operand to ALU A.
- alu_b  out  WIDTH  registered operand to ALU B.
- alu_sel  out  2  registered select to ALU_Sel.
- alu_out  in  WIDTH  ALU_Out.
- alu_carry  in  1  ALU CarryOut.
- alu_zf  in  1  ALU ZF.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  captured result.
- rsp_carry  out  1  captured carry.
- rsp_zf  out  1  captured zero flag.
- rsp_tag  out  TAG_W  echoed tag.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: all outputs are 0, the state is IDLE, the accumulator (last result) is 0, and the settle counter is 0.
- FSM states:
  - IDLE: req_ready=1. When req_valid is high, accept at the edge: load alu_a (accumulator if req_chain, else req_a), alu_b, alu_sel and the tag; set counter=SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: req_ready=0. Hold the ALU inputs stable. When counter==0, go to CAPTURE at the next edge; otherwise decrement.
  - CAPTURE: register alu_out, alu_carry and alu_zf into the rsp_* fields and the accumulator; set rsp_valid=1; go to RESP.
  - RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0. On rsp_ready, clear rsp_valid and go to IDLE.
- Latency: rsp_valid rises SETTLE_CYCLES+1 edges after the accepting edge. Minimum issue interval is SETTLE_CYCLES+3 cycles.
- Backpressure: there is no skid buffer. A request present while in RESP is not accepted until IDLE, even if rsp_ready is high that cycle.
- Operand hold: alu_a, alu_b and alu_sel keep their last values in IDLE and RESP; they are not zeroed.
- Carry is forwarded raw. The ALU carry is the add carry regardless of select, and rsp_carry is meaningful only for sel=00.
- Arithmetic: multiply and shift results are truncated to WIDTH by the ALU; the driver does no widening.
- Reset mid-operation: returns to IDLE immediately. Any in-flight op is dropped and no response is produced.
- req_chain on the first op after reset uses A=0.

Optional Feature:
- Macro: ALU_DRV_CHECK_EN.
- When defined:
  - adds output rsp_err (1 bit, reset 0);
  - at CAPTURE, recomputes the expected result from the registered operands and select using the package reference function;
  - sets rsp_err with rsp_valid if the data or ZF differs, and for sel=00 also if the carry differs;
  - clears rsp_err with rsp_valid.
- When undefined: no port and no logic; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - select constants ALU_ADD=2'b00, ALU_MUL=2'b01, ALU_XOR=2'b10, ALU_SHL=2'b11;
  - the FSM state encoding (IDLE, SETTLE, CAPTURE, RESP);
  - a reference function alu_model(a, b, sel) returning {carry, zf, result}, used by the checker and the bench.
- No sub-module. The FSM and datapath are small; the ALU is instantiated beside the driver, not inside it.

Test Plan:
- Add: A=0x0F, B=0x01, sel=00 -> rsp_data=0x10, carry=0, zf=0; rsp_valid rises at edge 2 after accept with SETTLE_CYCLES=1.
- Overflow: A=0xFF, B=0x01, sel=00 -> rsp_data=0x00, carry=1, zf=1.
- Mul truncation: A=0x10, B=0x10, sel=01 -> rsp_data=0x00, zf=1, carry=0. Then A=0x03, B=0x05 -> 0x0F.
- Chain: A=0x03, B=0x04, sel=00 -> 0x07. Then chain=1, sel=11 -> 0x0E. Then chain=1, B=0xFF, sel=10 -> 0xF1.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_* stable, req_ready=0 throughout; second request accepted only in the IDLE cycle after the response handshake; tags 0x3 then 0x4 return in order.
- Reset mid-SETTLE (SETTLE_CYCLES=4, assert rst_n low at cycle 2) -> outputs 0 asynchronously, no rsp_valid; the next chain op uses A=0. With ALU_DRV_CHECK_EN, a forced ALU output mismatch sets rsp_err=1.
